// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin arbiter in front of a single-port fixed-latency memory
//
// Purpose:
//   Shares one single-port memory between an instruction-fetch (IF) port and a
//   load/store data (D) port. One access is in flight at a time. Each access
//   moves through ISSUE -> WAIT -> RESP. Requests are sampled only in IDLE and
//   RESP, so a new access can issue straight out of RESP.
//
// Parameters:
//   WAIT_CYC   memory read latency in cycles after the issue cycle (1..15)
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   if_req, if_addr               fetch request (held until if_gnt) and word address
//   if_gnt, if_rvalid, if_rdata   fetch accept pulse, data-valid pulse, fetch data
//   d_req, d_we, d_be,
//   d_addr, d_wdata               load/store request, write enable, byte enables, address, write data
//   d_gnt, d_rvalid, d_rdata      data accept pulse, completion pulse, load data (0 for stores)
//   mem_en, mem_we, mem_be,
//   mem_addr, mem_wdata           memory command; en/we/be are high only in the issue cycle
//   mem_rdata                     memory read data, captured only at the end of WAIT
//   busy                          high whenever the arbiter is not idle

module mem_arbiter #(
    parameter int unsigned WAIT_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,

    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

    state_t      state;
    logic [3:0]  wait_cnt;

    // Owner of the access in flight and the last owner granted (1 = D, 0 = IF).
    logic        own_d;
    logic        last_d;

    // Command latched at the arbitration edge; mem_addr/mem_wdata expose these
    // directly so they stay stable outside the issue cycle.
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_we;
    logic [3:0]  lat_be;

    logic        arb_any;
    logic        arb_pick_d;

    // Round-robin: D wins only when IF is absent, or on a tie when IF was
    // granted last. Reset leaves last_d = 1 so IF takes the first tie.
    assign arb_any    = if_req | d_req;
    assign arb_pick_d = d_req & (~if_req | ~last_d);

    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            own_d     <= 1'b0;
            last_d    <= 1'b1;
            lat_addr  <= 32'h0;
            lat_wdata <= 32'h0;
            lat_we    <= 1'b0;
            lat_be    <= 4'h0;
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= 32'h0;
            d_rdata   <= 32'h0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'h0;
        end else begin
            // Pulse outputs default low; each is raised only for the single
            // cycle its state lasts.
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'h0;

            case (state)
                IDLE, RESP: begin
                    if (arb_any) begin
                        state     <= ISSUE;
                        own_d     <= arb_pick_d;
                        last_d    <= arb_pick_d;
                        lat_addr  <= arb_pick_d ? d_addr : if_addr;
                        lat_we    <= arb_pick_d & d_we;
                        lat_be    <= arb_pick_d ? d_be : 4'hF;
                        lat_wdata <= d_wdata;
                        // The issue-cycle outputs are loaded from the same
                        // values as the latches so they are valid in ISSUE.
                        if_gnt    <= ~arb_pick_d;
                        d_gnt     <= arb_pick_d;
                        mem_en    <= 1'b1;
                        mem_we    <= arb_pick_d & d_we;
                        mem_be    <= arb_pick_d ? d_be : 4'hF;
                    end else begin
                        state     <= IDLE;
                    end
                end

                ISSUE: begin
                    state    <= WAIT;
                    wait_cnt <= WAIT_INIT;
                end

                WAIT: begin
                    if (wait_cnt == 4'd1) begin
                        // Capture edge: the only edge where mem_rdata is used.
                        state    <= RESP;
                        wait_cnt <= 4'd0;
                        if (own_d) begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= lat_we ? 32'h0 : mem_rdata;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Lint-visible use of the latched enables; they mirror the issue-cycle
    // command and are kept for observability in the latch set.
    logic unused_lat;
    assign unused_lat = ^{lat_be, lat_we};

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter

module tb_mem_arbiter;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;

    logic        u1_if_req;
    logic [31:0] u1_if_addr;
    logic        u1_if_gnt, u1_if_rvalid;
    logic [31:0] u1_if_rdata;
    logic        u1_d_req, u1_d_we;
    logic [3:0]  u1_d_be;
    logic [31:0] u1_d_addr, u1_d_wdata;
    logic        u1_d_gnt, u1_d_rvalid;
    logic [31:0] u1_d_rdata;
    logic        u1_mem_en, u1_mem_we;
    logic [3:0]  u1_mem_be;
    logic [31:0] u1_mem_addr, u1_mem_wdata, u1_mem_rdata;
    logic        u1_busy;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.WAIT_CYC(W)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.WAIT_CYC(1)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(u1_if_req), .if_addr(u1_if_addr), .if_gnt(u1_if_gnt),
        .if_rvalid(u1_if_rvalid), .if_rdata(u1_if_rdata),
        .d_req(u1_d_req), .d_we(u1_d_we), .d_be(u1_d_be), .d_addr(u1_d_addr),
        .d_wdata(u1_d_wdata), .d_gnt(u1_d_gnt), .d_rvalid(u1_d_rvalid), .d_rdata(u1_d_rdata),
        .mem_en(u1_mem_en), .mem_we(u1_mem_we), .mem_be(u1_mem_be), .mem_addr(u1_mem_addr),
        .mem_wdata(u1_mem_wdata), .mem_rdata(u1_mem_rdata), .busy(u1_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if_req = 1'b0; d_req = 1'b0;
        u1_if_req = 1'b0; u1_d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        bit          is_d;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          exp_gnt;
        int          exp_rv;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_rdata;
        int          exp_busy;
    } vec_t;

    vec_t vecs[5];

    task automatic apply_vec(input int idx, input vec_t v);
        int gc = -1, rc = -1, bc = 0, other = 0;
        logic        g_en = 0, g_we = 0;
        logic [3:0]  g_be = 0;
        logic [31:0] g_addr = 0, g_wdata = 0, g_rdata = 0;
        mem_rdata = v.rdata;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_be = v.be; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr; d_wdata = v.wdata;
        end
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (busy) bc++;
            if (v.is_d ? (if_gnt || if_rvalid) : (d_gnt || d_rvalid)) other++;
            if ((v.is_d ? d_gnt : if_gnt) && gc < 0) begin
                gc = c + 1;
                g_en = mem_en; g_we = mem_we; g_be = mem_be; g_addr = mem_addr; g_wdata = mem_wdata;
                if_req = 1'b0; d_req = 1'b0;
            end
            if ((v.is_d ? d_rvalid : if_rvalid) && rc < 0) begin
                rc = c + 1;
                g_rdata = v.is_d ? d_rdata : if_rdata;
            end
        end
        check($sformatf("vec%0d gnt_cycle", idx), 32'(gc), 32'(v.exp_gnt));
        check($sformatf("vec%0d rvalid_cycle", idx), 32'(rc), 32'(v.exp_rv));
        check($sformatf("vec%0d mem_en", idx), 32'(g_en), 32'h1);
        check($sformatf("vec%0d mem_we", idx), 32'(g_we), 32'(v.exp_we));
        check($sformatf("vec%0d mem_be", idx), 32'(g_be), 32'(v.exp_be));
        check($sformatf("vec%0d mem_addr", idx), g_addr, v.addr);
        if (v.is_d) check($sformatf("vec%0d mem_wdata", idx), g_wdata, v.wdata);
        check($sformatf("vec%0d rdata", idx), g_rdata, v.exp_rdata);
        check($sformatf("vec%0d busy_cycles", idx), 32'(bc), 32'(v.exp_busy));
        check($sformatf("vec%0d other_port_quiet", idx), 32'(other), 32'h0);
        check($sformatf("vec%0d addr_retained", idx), mem_addr, v.addr);
        check($sformatf("vec%0d en_low_after", idx), {mem_en, mem_we, mem_be}, 32'h0);
    endtask

    // Reference-model state for the randomized run: a schedule of edge
    // numbers rather than a state machine.
    int          e, free_at, gnt_e, resp_e;
    bit          last_d, own_d, t_we;
    logic [3:0]  t_be;
    logic [31:0] t_addr, t_wdata, x_if_rdata, x_d_rdata;
    bit          m_gnt_if, m_gnt_d;

    int who[4], at[4];
    int n, both, cnt, rc, bc;
    logic [31:0] got;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        if_addr = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
        u1_if_addr = 0; u1_d_we = 0; u1_d_be = 0; u1_d_addr = 0; u1_d_wdata = 0; u1_mem_rdata = 0;
        if_req = 0; d_req = 0; u1_if_req = 0; u1_d_req = 0;

        vecs[0] = '{0, 0, 4'h0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 1, 4, 1'b0, 4'hF, 32'hDEAD_BEEF, 4};
        vecs[1] = '{1, 1, 4'h3, 32'h0000_0200, 32'h1234_5678, 32'hA5A5_A5A5, 1, 4, 1'b1, 4'h3, 32'h0,         4};
        vecs[2] = '{1, 0, 4'h4, 32'h0000_0300, 32'h0,         32'hCAFE_F00D, 1, 4, 1'b0, 4'h4, 32'hCAFE_F00D, 4};
        vecs[3] = '{0, 0, 4'h0, 32'hFFFF_FFFC, 32'h0,         32'h0,         1, 4, 1'b0, 4'hF, 32'h0,         4};
        vecs[4] = '{1, 1, 4'hF, 32'h0000_0004, 32'hFFFF_FFFF, 32'h5555_5555, 1, 4, 1'b1, 4'hF, 32'h0,         4};

        // Reset state, checked while reset is still asserted.
        rst = 1'b1;
        @(posedge clk); #1;
        check("reset busy", 32'(busy), 32'h0);
        check("reset pulses", {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, mem_be}, 32'h0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset rdata", if_rdata | d_rdata | mem_wdata, 32'h0);
        do_reset();

        foreach (vecs[i]) apply_vec(i, vecs[i]);

        // Both requests held: IF, D, IF, D, grants four cycles apart.
        do_reset();
        if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_we = 0; d_addr = 32'h20; d_be = 4'hF;
        n = 0; both = 0;
        foreach (who[i]) begin who[i] = -1; at[i] = -1; end
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            if (if_gnt && d_gnt) both++;
            if ((if_gnt || d_gnt) && n < 4) begin who[n] = d_gnt ? 1 : 0; at[n] = c; n++; end
        end
        if_req = 0; d_req = 0;
        check("rr grant_count", 32'(n), 32'd4);
        check("rr never_both", 32'(both), 32'h0);
        check("rr first_at_edge0", 32'(at[0]), 32'h0);
        for (int i = 0; i < 4; i++) check($sformatf("rr owner%0d", i), 32'(who[i]), 32'(i % 2));
        for (int i = 1; i < 4; i++) check($sformatf("rr spacing%0d", i), 32'(at[i] - at[i-1]), 32'd4);
        repeat (8) @(posedge clk);

        // Reset asserted mid-ISSUE, then mid-WAIT, away from any clock edge.
        do_reset();
        if_req = 1'b1; if_addr = 32'h40;
        @(posedge clk); #1;
        if_req = 1'b0;
        check("rst_issue gnt_before", 32'(if_gnt), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("rst_issue gnt_after", 32'(if_gnt), 32'h0);
        check("rst_issue en_after", 32'(mem_en), 32'h0);
        check("rst_issue busy_after", 32'(busy), 32'h0);
        check("rst_issue addr_cleared", mem_addr, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h44;
        @(posedge clk); #1 if_req = 1'b0;
        @(posedge clk); #1;
        check("rst_wait busy_before", 32'(busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("rst_wait busy_after", 32'(busy), 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (if_gnt || d_gnt || if_rvalid || d_rvalid || busy || mem_en) cnt++;
        end
        check("rst_wait quiet_after_release", 32'(cnt), 32'h0);

        // mem_rdata changes every cycle; only the capture-edge value lands.
        do_reset();
        d_req = 1'b1; d_we = 0; d_be = 4'hF; d_addr = 32'h80; mem_rdata = 32'hAAAA_0000;
        rc = -1; got = 32'h0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (d_gnt) d_req = 1'b0;
            if (d_rvalid && rc < 0) begin rc = c + 1; got = d_rdata; end
            mem_rdata = 32'h1000_0000 + 32'(c);
        end
        check("toggle rvalid_cycle", 32'(rc), 32'd4);
        check("toggle rdata", got, 32'h1000_0002);
        check("toggle rdata_held", d_rdata, 32'h1000_0002);

        // WAIT_CYC = 1 instance: single D read.
        do_reset();
        u1_d_req = 1'b1; u1_d_we = 0; u1_d_be = 4'hF; u1_d_addr = 32'h44; u1_mem_rdata = 32'h0BAD_F00D;
        rc = -1; bc = 0; got = 32'h0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (u1_busy) bc++;
            if (u1_d_gnt) u1_d_req = 1'b0;
            if (u1_d_rvalid && rc < 0) begin rc = c + 1; got = u1_d_rdata; end
        end
        check("w1 rvalid_cycle", 32'(rc), 32'd3);
        check("w1 busy_cycles", 32'(bc), 32'd3);
        check("w1 rdata", got, 32'h0BAD_F00D);

        // Randomized traffic against the schedule model.
        do_reset();
        e = 0; free_at = 0; gnt_e = -100; resp_e = -100; last_d = 1; own_d = 0;
        t_we = 0; t_be = 0; t_addr = 0; t_wdata = 0; x_if_rdata = 0; x_d_rdata = 0;
        for (int k = 0; k < 500; k++) begin
            @(posedge clk);
            m_gnt_if = 0; m_gnt_d = 0;
            if (e >= free_at && (if_req || d_req)) begin
                own_d   = d_req && (!if_req || !last_d);
                last_d  = own_d;
                t_we    = own_d ? d_we : 1'b0;
                t_be    = own_d ? d_be : 4'hF;
                t_addr  = own_d ? d_addr : if_addr;
                t_wdata = d_wdata;
                gnt_e   = e;
                resp_e  = e + 1 + W;
                free_at = e + 2 + W;
                m_gnt_d = own_d; m_gnt_if = !own_d;
            end
            if (e == resp_e) begin
                if (own_d) x_d_rdata = t_we ? 32'h0 : mem_rdata;
                else       x_if_rdata = mem_rdata;
            end
            #1;
            check("rnd if_gnt", 32'(if_gnt), 32'(m_gnt_if));
            check("rnd d_gnt", 32'(d_gnt), 32'(m_gnt_d));
            check("rnd mem_en", 32'(mem_en), 32'(e == gnt_e));
            check("rnd mem_we", 32'(mem_we), 32'((e == gnt_e) && t_we));
            check("rnd mem_be", 32'(mem_be), (e == gnt_e) ? 32'(t_be) : 32'h0);
            check("rnd mem_addr", mem_addr, t_addr);
            check("rnd mem_wdata", mem_wdata, t_wdata);
            check("rnd if_rvalid", 32'(if_rvalid), 32'((e == resp_e) && !own_d));
            check("rnd d_rvalid", 32'(d_rvalid), 32'((e == resp_e) && own_d));
            check("rnd if_rdata", if_rdata, x_if_rdata);
            check("rnd d_rdata", d_rdata, x_d_rdata);
            check("rnd busy", 32'(busy), 32'((e >= gnt_e) && (e <= resp_e)));
            if (m_gnt_if) if_req = 1'b0;
            if (m_gnt_d)  d_req  = 1'b0;
            if (!if_req && !m_gnt_if && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = $urandom;
            end
            if (!d_req && !m_gnt_d && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom); d_be = 4'($urandom);
                d_addr = $urandom; d_wdata = $urandom;
            end
            mem_rdata = $urandom;
            e++;
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
